// File: rtl/cursor_pkg.sv
// Shared types and helpers for the board cursor / select controller.
package cursor_pkg;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } sel_state_t;

  // One wrapping step on an index in 0..max-1; dir=1 increments, dir=0 decrements.
  function automatic int unsigned wrap_step(input int unsigned idx,
                                            input int unsigned max,
                                            input logic        dir);
    if (dir) begin
      return (idx >= max - 32'd1) ? 32'd0 : idx + 32'd1;
    end
    return (idx == 32'd0) ? max - 32'd1 : idx - 32'd1;
  endfunction

endpackage

// File: rtl/cursor_select_ctrl_btn_edge.sv
// Rising-edge detector for one debounced button; history starts high so a
// button held through reset produces no event.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic pulse
);

  logic lvl_q;

  // Previous-sample history register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q <= 1'b1;
    end else begin
      lvl_q <= lvl;
    end
  end

  assign pulse = lvl & ~lvl_q;

endmodule

// File: rtl/cursor_select_ctrl.sv
// Wrapping board cursor driven by button events, plus a handshaked one-shot
// selection of the cell under the cursor.
module cursor_select_ctrl
  import cursor_pkg::*;
#(
  parameter int unsigned ROWS = 6,
  parameter int unsigned COLS = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_up,
  input  logic                     btn_down,
  input  logic                     btn_left,
  input  logic                     btn_right,
  input  logic                     btn_sel,
  input  logic                     lock,
  output logic [$clog2(ROWS)-1:0]  cursor_row,
  output logic [$clog2(COLS)-1:0]  cursor_col,
  output logic                     move_strb,
  output logic                     sel_valid,
  output logic [$clog2(ROWS)-1:0]  sel_row,
  output logic [$clog2(COLS)-1:0]  sel_col,
  input  logic                     sel_ready
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);

  logic ev_up, ev_down, ev_left, ev_right, ev_sel;

  btn_edge u_edge_up    (.clk(clk), .rst(rst), .lvl(btn_up),    .pulse(ev_up));
  btn_edge u_edge_down  (.clk(clk), .rst(rst), .lvl(btn_down),  .pulse(ev_down));
  btn_edge u_edge_left  (.clk(clk), .rst(rst), .lvl(btn_left),  .pulse(ev_left));
  btn_edge u_edge_right (.clk(clk), .rst(rst), .lvl(btn_right), .pulse(ev_right));
  btn_edge u_edge_sel   (.clk(clk), .rst(rst), .lvl(btn_sel),   .pulse(ev_sel));

  sel_state_t    state, state_n;
  logic [RW-1:0] row_n, sel_row_n;
  logic [CW-1:0] col_n, sel_col_n;
  logic          move_n;
  logic          row_mv, col_mv;

  // Opposing events on one axis cancel each other.
  assign row_mv = ev_up ^ ev_down;
  assign col_mv = ev_left ^ ev_right;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cursor_row <= '0;
      cursor_col <= '0;
      move_strb  <= 1'b0;
      sel_valid  <= 1'b0;
      sel_row    <= '0;
      sel_col    <= '0;
    end else begin
      state      <= state_n;
      cursor_row <= row_n;
      cursor_col <= col_n;
      move_strb  <= move_n;
      sel_valid  <= (state_n == S_PENDING);
      sel_row    <= sel_row_n;
      sel_col    <= sel_col_n;
    end
  end

  // Next-state, cursor movement and selection capture.
  always_comb begin
    state_n   = state;
    row_n     = cursor_row;
    col_n     = cursor_col;
    sel_row_n = sel_row;
    sel_col_n = sel_col;
    move_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (row_mv) begin
          row_n = RW'(wrap_step(32'(cursor_row), ROWS, ev_down));
        end
        if (col_mv) begin
          col_n = CW'(wrap_step(32'(cursor_col), COLS, ev_right));
        end
        move_n = row_mv | col_mv;
        // Selection captures the cursor as it was before any same-cycle move.
        if (ev_sel && !lock) begin
          state_n   = S_PENDING;
          sel_row_n = cursor_row;
          sel_col_n = cursor_col;
        end
      end
      S_PENDING: begin
        if (sel_ready) begin
          state_n = S_IDLE;
        end
      end
    endcase
  end

endmodule
